// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single SRAM port; ARB_STARVE_GUARD_EN enables fetch starvation guard
module mem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    if (MAX_WAIT < 1 || MAX_WAIT > 7) begin : g_bad_max_wait
        $error("mem_arbiter: MAX_WAIT must be in 1..7");
    end

    // owner_q[1]: fetch read in flight, owner_q[0]: data read in flight
    logic [1:0] owner_q;
    logic [1:0] owner_d;
    logic       force_i;
    logic       i_gnt_c;
    logic       d_gnt_c;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [2:0] MAX_WAIT_C = 3'(MAX_WAIT);

    logic [2:0] starve_q;
    logic [2:0] starve_d;

    always_comb begin
        starve_d = starve_q;
        if (!i_req || i_gnt_c) begin
            starve_d = 3'd0;
        end else if (starve_q != 3'd7) begin
            starve_d = starve_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_q <= 3'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign force_i = i_req && (starve_q == MAX_WAIT_C);
`else
    assign force_i = 1'b0;
`endif

    // Grants are gated by rstn so nothing reaches the SRAM while reset is held.
    always_comb begin
        d_gnt_c = rstn && d_req && !force_i;
        i_gnt_c = rstn && i_req && !d_gnt_c;
    end

    always_comb begin
        sram_en    = i_gnt_c | d_gnt_c;
        sram_we    = 4'b0000;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        if (d_gnt_c) begin
            sram_we    = d_we;
            sram_addr  = d_addr;
            sram_wdata = d_wdata;
        end else if (i_gnt_c) begin
            sram_addr = i_addr;
        end
    end

    // Fetches are always reads; data writes leave no response owner.
    always_comb begin
        owner_d = {i_gnt_c, d_gnt_c && (d_we == 4'b0000)};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner_q <= 2'b00;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        i_gnt    = i_gnt_c;
        d_gnt    = d_gnt_c;
        i_rvalid = owner_q[1];
        d_rvalid = owner_q[0];
        i_rdata  = owner_q[1] ? sram_rdata : 32'h0;
        d_rdata  = owner_q[0] ? sram_rdata : 32'h0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (vector table, directed sequences, random vs reference model)
module tb_mem_arbiter;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic [3:0]  d_we = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;

    mem_arbiter #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: grant rule from the priority text, responses as a time-stamped queue.
    typedef struct {
        int cyc;
        bit to_d;
    } resp_t;
    resp_t rq[$];
    int    cyc_n = 0;
    int    wait_cnt = 0;
    bit    m_i, m_d;
    bit    guard_on;

    task automatic model_compare();
        bit fetch_forced;
        bit exp_iv, exp_dv;
        fetch_forced = guard_on && i_req && (wait_cnt == MW);
        m_d = rstn && d_req && !fetch_forced;
        m_i = rstn && i_req && !m_d;
        chk("m_i_gnt", i_gnt, m_i);
        chk("m_d_gnt", d_gnt, m_d);
        chk("m_sram_en", sram_en, m_i | m_d);
        chk("m_sram_we", sram_we, m_d ? d_we : 4'b0);
        if (m_d) begin
            chk("m_sram_addr_d", sram_addr, d_addr);
            chk("m_sram_wdata_d", sram_wdata, d_wdata);
        end else if (m_i) begin
            chk("m_sram_addr_i", sram_addr, i_addr);
            chk("m_sram_wdata_i", sram_wdata, 32'h0);
        end
        while (rq.size() > 0 && rq[0].cyc < cyc_n - 1) void'(rq.pop_front());
        exp_iv = 1'b0;
        exp_dv = 1'b0;
        if (rstn && rq.size() > 0 && rq[0].cyc == cyc_n - 1) begin
            exp_iv = !rq[0].to_d;
            exp_dv = rq[0].to_d;
        end
        chk("m_i_rvalid", i_rvalid, exp_iv);
        chk("m_d_rvalid", d_rvalid, exp_dv);
        chk("m_i_rdata", i_rdata, exp_iv ? sram_rdata : 32'h0);
        chk("m_d_rdata", d_rdata, exp_dv ? sram_rdata : 32'h0);
    endtask

    task automatic model_advance();
        if (!rstn) begin
            rq.delete();
            wait_cnt = 0;
        end else begin
            if (m_i) rq.push_back('{cyc: cyc_n, to_d: 1'b0});
            if (m_d && d_we == 4'b0) rq.push_back('{cyc: cyc_n, to_d: 1'b1});
            if (i_req && !m_i) wait_cnt = (wait_cnt < 7) ? wait_cnt + 1 : 7;
            else wait_cnt = 0;
        end
        cyc_n++;
    endtask

    task automatic step_begin();
        sram_rdata = $urandom;
        @(negedge clk);
        model_compare();
    endtask

    task automatic step_end();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit ir, input logic [31:0] ia, input bit dr,
                         input logic [3:0] we, input logic [31:0] da, input logic [31:0] wd);
        i_req = ir; i_addr = ia; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, 0, 0);
        step_begin();
        step_end();
    endtask

    typedef struct {
        bit          ir;
        bit          dr;
        logic [3:0]  we;
        logic [31:0] ia;
        logic [31:0] da;
        bit          exp_ig;
        bit          exp_dg;
    } vec_t;

    vec_t vecs[6];

    initial begin
`ifdef ARB_STARVE_GUARD_EN
        guard_on = 1'b1;
`else
        guard_on = 1'b0;
`endif
        vecs[0] = '{ir: 1, dr: 1, we: 4'b0000, ia: 32'h40, da: 32'h100, exp_ig: 0, exp_dg: 1};
        vecs[1] = '{ir: 1, dr: 0, we: 4'b0000, ia: 32'h44, da: 32'h0,   exp_ig: 1, exp_dg: 0};
        vecs[2] = '{ir: 0, dr: 1, we: 4'b0011, ia: 32'h0,  da: 32'h208, exp_ig: 0, exp_dg: 1};
        vecs[3] = '{ir: 0, dr: 0, we: 4'b0000, ia: 32'h0,  da: 32'h0,   exp_ig: 0, exp_dg: 0};
        vecs[4] = '{ir: 1, dr: 1, we: 4'b1111, ia: 32'h48, da: 32'h30C, exp_ig: 0, exp_dg: 1};
        vecs[5] = '{ir: 0, dr: 1, we: 4'b0000, ia: 32'h0,  da: 32'h410, exp_ig: 0, exp_dg: 1};

        // Reset held with both requests pending: everything quiet.
        drive(1, 32'h10, 1, 4'b0000, 32'h20, 32'h0);
        #1;
        step_begin();
        chk("rst_i_gnt", i_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_sram_en", sram_en, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
        chk("rst_rdata", i_rdata | d_rdata, 0);
        step_end();
        rstn = 1'b1;
        idle_cycle();

        // Vector table, each vector followed by an idle cycle that carries its response.
        for (int k = 0; k < 6; k++) begin
            drive(vecs[k].ir, vecs[k].ia, vecs[k].dr, vecs[k].we, vecs[k].da, 32'hA5A50000 + k);
            step_begin();
            chk($sformatf("vec%0d_i_gnt", k), i_gnt, vecs[k].exp_ig);
            chk($sformatf("vec%0d_d_gnt", k), d_gnt, vecs[k].exp_dg);
            chk($sformatf("vec%0d_sram_en", k), sram_en, vecs[k].exp_ig | vecs[k].exp_dg);
            if (vecs[k].exp_dg) chk($sformatf("vec%0d_sram_addr", k), sram_addr, vecs[k].da);
            if (vecs[k].exp_ig) chk($sformatf("vec%0d_sram_addr", k), sram_addr, vecs[k].ia);
            step_end();
            drive(0, 0, 0, 0, 0, 0);
            step_begin();
            chk($sformatf("vec%0d_i_rvalid", k), i_rvalid, vecs[k].exp_ig);
            chk($sformatf("vec%0d_d_rvalid", k), d_rvalid, vecs[k].exp_dg && vecs[k].we == 4'b0);
            if (d_rvalid) chk($sformatf("vec%0d_d_rdata", k), d_rdata, sram_rdata);
            step_end();
        end

        // Both requesters held high.
`ifdef ARB_STARVE_GUARD_EN
        for (int c = 1; c <= 6; c++) begin
            drive(1, 32'h80, 1, 4'b0000, 32'h180, 0);
            step_begin();
            chk($sformatf("starve_c%0d_i_gnt", c), i_gnt, c == 5);
            chk($sformatf("starve_c%0d_d_gnt", c), d_gnt, c != 5);
            step_end();
        end
`else
        for (int c = 1; c <= 20; c++) begin
            drive(1, 32'h80, 1, 4'b0000, 32'h180, 0);
            step_begin();
            chk($sformatf("nostarve_c%0d_i_gnt", c), i_gnt, 0);
            step_end();
        end
`endif
        idle_cycle();

        // Write then fetch read with no bubble.
        drive(0, 0, 1, 4'b0011, 32'h200, 32'hDEADBEEF);
        step_begin();
        chk("wr_sram_we", sram_we, 4'b0011);
        chk("wr_sram_wdata", sram_wdata, 32'hDEADBEEF);
        step_end();
        drive(1, 32'h300, 0, 0, 0, 0);
        step_begin();
        chk("wr_rd_i_gnt", i_gnt, 1);
        chk("wr_rd_sram_we", sram_we, 0);
        chk("wr_rd_rvalid", {i_rvalid, d_rvalid}, 2'b00);
        step_end();
        drive(0, 0, 0, 0, 0, 0);
        step_begin();
        chk("wr_rd_i_rvalid", i_rvalid, 1);
        chk("wr_rd_i_rdata", i_rdata, sram_rdata);
        chk("wr_rd_d_rvalid", d_rvalid, 0);
        step_end();
        step_begin();
        chk("wr_rd_after", {i_rvalid, d_rvalid}, 2'b00);
        step_end();

        // Data read granted, then reset pulses in the following cycle.
        drive(0, 0, 1, 4'b0000, 32'h500, 0);
        step_begin();
        chk("rr_d_gnt", d_gnt, 1);
        step_end();
        drive(1, 32'h10, 1, 4'b0000, 32'h504, 0);
        rstn = 1'b0;
        step_begin();
        chk("rr_during_d_rvalid", d_rvalid, 0);
        chk("rr_during_d_rdata", d_rdata, 0);
        chk("rr_during_sram_en", sram_en, 0);
        chk("rr_during_gnt", {i_gnt, d_gnt}, 0);
        step_end();
        rstn = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step_begin();
        chk("rr_after_d_rvalid", d_rvalid, 0);
        chk("rr_after_i_rvalid", i_rvalid, 0);
        step_end();

        // Alternating back-to-back reads.
        for (int k = 0; k < 5; k++) begin
            if (k < 4) drive(k % 2 == 0, 32'(4 * k), k % 2 == 1, 4'b0000, 32'(4 * k), 0);
            else drive(0, 0, 0, 0, 0, 0);
            step_begin();
            if (k < 4) begin
                chk($sformatf("alt%0d_i_gnt", k), i_gnt, k % 2 == 0);
                chk($sformatf("alt%0d_d_gnt", k), d_gnt, k % 2 == 1);
                chk($sformatf("alt%0d_sram_addr", k), sram_addr, 32'(4 * k));
            end
            if (k > 0) begin
                chk($sformatf("alt%0d_i_rvalid", k), i_rvalid, (k - 1) % 2 == 0);
                chk($sformatf("alt%0d_d_rvalid", k), d_rvalid, (k - 1) % 2 == 1);
            end
            step_end();
        end

        // Random traffic; denied requests are held by the requester.
        for (int n = 0; n < 400; n++) begin
            if (!(i_req && !m_i)) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = {$urandom} & 32'hFFFF_FFFC;
            end
            if (!(d_req && !m_d)) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            step_begin();
            step_end();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
